// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit drain: FSM encodings and line levels.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL     = 1'b0;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Show-ahead fifo read port between the TX fifo (master) and the drain stage (slave).
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_pop;

    modport master (output fifo_dout, output fifo_empty, input fifo_pop);
    modport slave  (input fifo_dout, input fifo_empty, output fifo_pop);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..div_q and ticks on the terminal count.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div_q,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q;

    assign tick = (cnt_q == div_q);

    // Restarting on every tick keeps the count bounded by div_q.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_drain.sv
// Drains bytes from the TX fifo and serialises them as 8N1/8N2 on tx.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | line high; pops and loads the head byte when fifo non-empty
//  ST_START | start bit (low) for one bit period
//  ST_DATA  | DATA_WIDTH data bits, LSB first
//  ST_STOP  | STOP_BITS stop bits (high), then back to idle
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    uart_tx_drain_if.slave       fifo,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tx,
    output logic                 busy
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  pop;
    logic                  tick;

    assign pop           = (state_q == ST_IDLE) & ~fifo.fifo_empty & resetn;
    assign fifo.fifo_pop = pop;
    assign tx            = tx_q;
    assign busy          = busy_q;

    // Cleared on the pop edge so the start bit always lasts a full period.
    uart_baud_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk    (clk),
        .resetn (resetn),
        .clear  (pop),
        .div_q  (div_q),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= UART_IDLE_LEVEL;
                    if (!fifo.fifo_empty) begin
                        shreg_q   <= fifo.fifo_dout;
                        div_q     <= div;
                        bit_cnt_q <= '0;
                        tx_q      <= START_LEVEL;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_q      <= shreg_q[0];
                        shreg_q   <= {1'b0, shreg_q[DATA_WIDTH-1:1]};
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            tx_q      <= UART_IDLE_LEVEL;
                            bit_cnt_q <= '0;
                            state_q   <= ST_STOP;
                        end else begin
                            tx_q      <= shreg_q[0];
                            shreg_q   <= {1'b0, shreg_q[DATA_WIDTH-1:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            busy_q    <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= UART_IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: fifo modelled by queues, two instances (1 and 2 stop bits).
module tb_uart_tx_drain;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] d0, d1;
    logic        tx0, busy0, tx1, busy1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pops0  = 0;
    int pops1  = 0;

    uart_tx_drain_if #(.DATA_WIDTH(8)) f0 ();
    uart_tx_drain_if #(.DATA_WIDTH(8)) f1 ();

    uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16), .STOP_BITS(1)) dut0 (
        .clk(clk), .resetn(resetn), .fifo(f0.slave), .div(d0), .tx(tx0), .busy(busy0));
    uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(16), .STOP_BITS(2)) dut1 (
        .clk(clk), .resetn(resetn), .fifo(f1.slave), .div(d1), .tx(tx1), .busy(busy1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        f0.fifo_empty = (q0.size() == 0);
        f0.fifo_dout  = (q0.size() != 0) ? q0[0] : 8'hEE;
        f1.fifo_empty = (q1.size() == 0);
        f1.fifo_dout  = (q1.size() != 0) ? q1[0] : 8'hEE;
        #1;
    endtask

    // One clock: pop strobes sampled before the edge retire the fifo head after it.
    task automatic step();
        logic p0, p1;
        p0 = f0.fifo_pop;
        p1 = f1.fifo_pop;
        @(posedge clk);
        #1;
        if (p0 && q0.size() != 0) begin void'(q0.pop_front()); pops0++; end
        if (p1 && q1.size() != 0) begin void'(q1.pop_front()); pops1++; end
        upd();
        cyc++;
        if (cyc > 20000) begin
            $display("FAIL cycle_budget observed=%0d expected<=20000", cyc);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    function automatic logic cur_tx(input int u);
        return (u == 0) ? tx0 : tx1;
    endfunction
    function automatic logic cur_busy(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction
    function automatic logic cur_pop(input int u);
        return (u == 0) ? f0.fifo_pop : f1.fifo_pop;
    endfunction

    // Checks one frame cycle by cycle from the pop cycle, then decodes it like a receiver.
    task automatic frame(input int u, input logic [7:0] b, input int dv, input int stops,
                         input int chg_k, input int new_div, input string tag);
        int   per, len, idx;
        logic expb;
        logic w[$];
        logic [7:0] rx;
        per = dv + 1;
        len = per * (1 + 8 + stops);
        chk({tag, " pop_start"}, cur_pop(u), 1'b1);
        for (int k = 1; k <= len + 1; k++) begin
            if (k == chg_k) begin
                if (u == 0) d0 = 16'(new_div); else d1 = 16'(new_div);
            end
            step();
            w.push_back(cur_tx(u));
            if (k <= len) begin
                idx  = (k - 1) / per;
                expb = (idx == 0) ? 1'b0 : (idx <= 8) ? b[idx-1] : 1'b1;
                chk($sformatf("%s tx k=%0d", tag, k), cur_tx(u), expb);
                chk($sformatf("%s busy k=%0d", tag, k), cur_busy(u), 1'b1);
                chk($sformatf("%s nopop k=%0d", tag, k), cur_pop(u), 1'b0);
            end else begin
                chk({tag, " idle_tx"}, cur_tx(u), 1'b1);
                chk({tag, " idle_busy"}, cur_busy(u), 1'b0);
            end
        end
        chk({tag, " rx_start"}, w[per/2], 1'b0);
        for (int i = 0; i < 8; i++) rx[i] = w[(i + 1) * per + per / 2];
        for (int s = 0; s < stops; s++)
            chk($sformatf("%s rx_stop%0d", tag, s), w[(9 + s) * per + per / 2], 1'b1);
        chk({tag, " rx_byte"}, rx, b);
    endtask

    initial begin
        int p;
        resetn = 1'b0;
        d0 = 16'd3;
        d1 = 16'd1;
        q0.push_back(8'h11);
        q1.push_back(8'h22);
        upd();

        // 1: reset held with non-empty fifos
        for (int i = 0; i < 3; i++) begin
            chk("rst pop0", f0.fifo_pop, 1'b0);
            chk("rst pop1", f1.fifo_pop, 1'b0);
            step();
            chk("rst tx0", tx0, 1'b1);
            chk("rst busy0", busy0, 1'b0);
            chk("rst tx1", tx1, 1'b1);
            chk("rst busy1", busy1, 1'b0);
        end
        chk("rst pops", pops0 + pops1, 0);
        q0.delete();
        q1.delete();
        upd();
        resetn = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty tx0", tx0, 1'b1);
            chk("empty busy0", busy0, 1'b0);
            chk("empty pop0", f0.fifo_pop, 1'b0);
        end

        // 2: single byte 0x55 at div=3
        p = pops0;
        d0 = 16'd3;
        q0.push_back(8'h55);
        upd();
        frame(0, 8'h55, 3, 1, 0, 0, "t2");
        chk("t2 pops", pops0 - p, 1);

        // 3: back-to-back at div=0
        p = pops0;
        d0 = 16'd0;
        q0.push_back(8'hA5);
        q0.push_back(8'h3C);
        upd();
        frame(0, 8'hA5, 0, 1, 0, 0, "t3a");
        frame(0, 8'h3C, 0, 1, 0, 0, "t3b");
        chk("t3 pops", pops0 - p, 2);

        // 4: div change during DATA only affects the next frame
        d0 = 16'd7;
        q0.push_back(8'hFF);
        q0.push_back(8'h0F);
        upd();
        frame(0, 8'hFF, 7, 1, 30, 1, "t4a");
        frame(0, 8'h0F, 1, 1, 0, 0, "t4b");

        // 5: reset during data bit 4 of 0x81
        d0 = 16'd1;
        q0.push_back(8'h81);
        upd();
        chk("t5 pop", f0.fifo_pop, 1'b1);
        for (int k = 1; k <= 11; k++) step();
        chk("t5 bit4 tx", tx0, 1'b0);
        chk("t5 bit4 busy", busy0, 1'b1);
        q0.push_back(8'h5A);
        upd();
        resetn = 1'b0;
        #1;
        chk("t5 rst pop", f0.fifo_pop, 1'b0);
        step();
        chk("t5 rst tx", tx0, 1'b1);
        chk("t5 rst busy", busy0, 1'b0);
        resetn = 1'b1;
        #1;
        frame(0, 8'h5A, 1, 1, 0, 0, "t5");

        // 6: two stop bits, div=1, byte 0x00
        d1 = 16'd1;
        p = pops1;
        q1.push_back(8'h00);
        upd();
        frame(1, 8'h00, 1, 2, 0, 0, "t6");
        chk("t6 pops", pops1 - p, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
